// File: rtl/rambus_arbiter.sv
// Round-robin Wishbone arbiter: NUM_CH masters share one RAM-bus slave; the owner holds the bus while its cyc is high.
// One idle cycle before each grant; slave paths are combinational while owned; a watchdog ends unacked strobes with m_err_o.
module rambus_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          m_cyc_i,
  input  logic [NUM_CH-1:0]          m_stb_i,
  input  logic [NUM_CH-1:0]          m_we_i,
  input  logic [NUM_CH*DATA_W/8-1:0] m_sel_i,
  input  logic [NUM_CH*ADDR_W-1:0]   m_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]   m_dat_i,
  output logic [NUM_CH-1:0]          m_ack_o,
  output logic [NUM_CH-1:0]          m_err_o,
  output logic [DATA_W-1:0]          m_dat_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic                       s_we_o,
  output logic [DATA_W/8-1:0]        s_sel_o,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic [DATA_W-1:0]          s_dat_o,
  input  logic                       s_ack_i,
  input  logic [DATA_W-1:0]          s_dat_i,
  output logic [NUM_CH-1:0]          grant_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   own_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [WD_W-1:0]    wd_q;
  logic [NUM_CH-1:0]  grant_q;

  logic [NUM_CH-1:0]  req;
  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [IDX_W-1:0]   next_ptr;
  logic               busy;
  logic               own_stb;
  logic               err_pulse;
  logic               stb_out;
  int                 own_idx;

  assign req = m_cyc_i & m_stb_i;

  // Scan downward so the requester closest at-or-after rr_ptr overwrites the others.
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_CH;
      if (req[idx]) begin
        pick     = IDX_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign next_ptr  = (own_q == IDX_W'(NUM_CH - 1)) ? '0 : own_q + 1'b1;
  assign own_idx   = int'(own_q);
  assign busy      = (state_q == ST_BUSY);
  assign own_stb   = busy & m_stb_i[own_q];
  assign err_pulse = own_stb & (wd_q == WD_MAX);
  assign stb_out   = own_stb & ~err_pulse;

  assign s_cyc_o  = busy & m_cyc_i[own_q];
  assign s_stb_o  = stb_out;
  assign s_we_o   = busy & m_we_i[own_q];
  assign s_sel_o  = busy ? m_sel_i[own_idx*SEL_W +: SEL_W]   : '0;
  assign s_addr_o = busy ? m_addr_i[own_idx*ADDR_W +: ADDR_W] : '0;
  assign s_dat_o  = busy ? m_dat_i[own_idx*DATA_W +: DATA_W]  : '0;

  // grant_q is one-hot of the owner while busy, so it doubles as the response demux.
  assign m_ack_o = (stb_out & s_ack_i) ? grant_q : '0;
  assign m_err_o = err_pulse ? grant_q : '0;
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      own_q    <= '0;
      rr_ptr_q <= '0;
      wd_q     <= '0;
      grant_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q <= ST_BUSY;
            own_q   <= pick;
            grant_q <= NUM_CH'(1) << pick;
            wd_q    <= '0;
          end
        end
        ST_BUSY: begin
          if (!m_cyc_i[own_q]) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= next_ptr;
            grant_q  <= '0;
            wd_q     <= '0;
          end else if (stb_out && !s_ack_i) begin
            wd_q <= wd_q + 1'b1;
          end else begin
            wd_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
